// File: rtl/apb_req_arbiter_if.sv
// ============================================================================
//  Module      : apb_req_arbiter_if
//  Description : Bundles the requester FIFO, response FIFO, APB-master packet
//                port and APB bus-monitor signals of apb_req_arbiter.
//                The master modport is the arbiter's view. The slave modport
//                is the environment's view (requesters, APB master, bus).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_req_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int PKT_W  = 41,
  parameter int DATA_W = 32
);
  // Requester side
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*PKT_W-1:0] req_packet;
  logic [NREQ-1:0]       req_read_en;
  logic [NREQ-1:0]       rsp_full;
  logic [NREQ-1:0]       rsp_valid;
  logic [DATA_W-1:0]     rsp_data;
  // APB master packet port
  logic [PKT_W-1:0]      Packet_IN;
  logic                  P_Valid;
  logic                  Packet_Read_en;
  logic                  Data_Write_en;
  logic [DATA_W-1:0]     Data_Out;
  logic                  Read_fifo_full;
  // APB bus monitor
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PREADY;
  // Debug / status
  logic [2:0]            grant_id;
  logic                  busy;

  modport master (
    input  req_valid, req_packet, rsp_full,
    input  Packet_Read_en, Data_Write_en, Data_Out,
    input  PSEL, PENABLE, PREADY,
    output req_read_en, rsp_valid, rsp_data,
    output Packet_IN, P_Valid, Read_fifo_full,
    output grant_id, busy
  );

  modport slave (
    output req_valid, req_packet, rsp_full,
    output Packet_Read_en, Data_Write_en, Data_Out,
    output PSEL, PENABLE, PREADY,
    input  req_read_en, rsp_valid, rsp_data,
    input  Packet_IN, P_Valid, Read_fifo_full,
    input  grant_id, busy
  );
endinterface

`default_nettype wire

// File: rtl/apb_req_arbiter.sv
// ============================================================================
//  Module      : apb_req_arbiter
//  Description : Shares one APB master between NREQ packet requesters.
//                It grants one eligible requester and holds that requester's
//                packet stable for the whole APB transfer. Read data is routed
//                back to the owning requester's response FIFO.
//                The default build uses round-robin arbitration.
//                Defining APB_ARB_FIXED_PRIO_EN selects fixed priority: the
//                lowest eligible index wins, and the rotation pointer is held
//                at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_req_arbiter #(
  parameter int NREQ   = 4,
  parameter int PKT_W  = 41,
  parameter int DATA_W = 32
) (
  input  wire logic           PCLK,
  input  wire logic           RESETn,
  apb_req_arbiter_if.master   bus
);

  localparam logic [1:0] c_ARB   = 2'b00;
  localparam logic [1:0] c_GRANT = 2'b01;
  localparam logic [1:0] c_BUSY  = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [2:0]       grant_id_q, grant_id_d;
  logic [PKT_W-1:0] hold_q, hold_d;
  logic [2:0]       rr_ptr_q;

  logic [PKT_W-1:0] pkt [NREQ];
  logic [NREQ-1:0]  eligible;

  logic [NREQ-1:0]  owner_oh;
  logic [PKT_W-1:0] owner_pkt;
  logic             owner_valid;
  logic             owner_full;

  logic             pick_found;
  logic [2:0]       pick_idx;
  logic             xfer_done;

  // A write packet never needs the response FIFO. A read packet waits until
  // the response FIFO has room.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign pkt[gi]      = bus.req_packet[gi*PKT_W +: PKT_W];
      assign eligible[gi] = bus.req_valid[gi] & (pkt[gi][PKT_W-1] | ~bus.rsp_full[gi]);
    end
  endgenerate

  assign xfer_done = bus.PSEL & bus.PENABLE & bus.PREADY;

  // Decode the current owner into a one-hot mask and its per-requester signals
  always_comb begin
    owner_oh    = '0;
    owner_pkt   = '0;
    owner_valid = 1'b0;
    owner_full  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == 3'(i)) begin
        owner_oh[i] = 1'b1;
        owner_pkt   = pkt[i];
        owner_valid = bus.req_valid[i];
        owner_full  = bus.rsp_full[i];
      end
    end
  end

  // Pick the first eligible requester at or after rr_ptr, wrapping around
  always_comb begin : p_pick
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!pick_found && (i == idx) && eligible[i]) begin
          pick_found = 1'b1;
          pick_idx   = 3'(i);
        end
      end
    end
  end

  // Arbitration FSM next-state logic
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    hold_d     = hold_q;
    case (state_q)
      c_ARB: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          state_d    = c_GRANT;
        end
      end
      c_GRANT: begin
        // If the requester FIFO was flushed under us, give up the grant
        // without popping.
        if (!owner_valid) begin
          state_d = c_ARB;
        end else if (bus.Packet_Read_en) begin
          hold_d  = owner_pkt;
          state_d = c_BUSY;
        end
      end
      c_BUSY: begin
        if (xfer_done) state_d = c_ARB;
      end
      default: state_d = c_ARB;
    endcase
  end

  // FSM, owner and held-packet registers
  always_ff @(posedge PCLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= c_ARB;
      grant_id_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      hold_q     <= hold_d;
    end
  end

`ifdef APB_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at requester 0
  assign rr_ptr_q = '0;
`else
  logic [2:0] rr_ptr_d;

  // On each completed transfer, move the pointer past the owner
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if ((state_q == c_BUSY) && xfer_done) begin
      rr_ptr_d = (grant_id_q == 3'(NREQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge PCLK or negedge RESETn) begin
    if (!RESETn) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Output decode, gated by state so that nothing leaks while idle
  always_comb begin
    bus.P_Valid        = (state_q == c_GRANT);
    bus.Packet_IN      = (state_q == c_GRANT) ? owner_pkt :
                         (state_q == c_BUSY)  ? hold_q    : '0;
    bus.req_read_en    = ((state_q == c_GRANT) && owner_valid && bus.Packet_Read_en) ? owner_oh : '0;
    bus.rsp_valid      = ((state_q == c_BUSY) && bus.Data_Write_en) ? owner_oh : '0;
    bus.rsp_data       = (state_q == c_BUSY) ? bus.Data_Out : '0;
    bus.Read_fifo_full = (state_q == c_BUSY) & owner_full;
    bus.busy           = (state_q != c_ARB);
    bus.grant_id       = grant_id_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
// ============================================================================
//  Module      : tb_apb_req_arbiter
//  Description : Directed self-checking bench for apb_req_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_req_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  logic [40:0] pkt [4];

  apb_req_arbiter_if #(.NREQ(4), .PKT_W(41), .DATA_W(32)) bus ();

  apb_req_arbiter #(.NREQ(4), .PKT_W(41), .DATA_W(32)) dut (
    .PCLK   (clk),
    .RESETn (rst_n),
    .bus    (bus)
  );

  assign bus.req_packet = {pkt[3], pkt[2], pkt[1], pkt[0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [40:0] wr_pkt(input int i);
    return {1'b1, 32'hA000_0000 | 32'(i), 8'(8'h20 + i)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full grant -> pop -> SETUP -> ACCESS (with optional waits) -> ARB cycle.
  // Starts just before the negedge where GRANT is expected.
  task automatic xfer(input int id, input bit rd, input logic [31:0] rdata,
                      input bit full_exp, input int waits);
    logic [40:0] p;
    logic [3:0]  oh;
    oh = 4'(1 << id);
    @(negedge clk); #1;
    p = pkt[id];
    check("grant_pvalid", 64'(bus.P_Valid), 64'd1);
    check("grant_id", 64'(bus.grant_id), 64'(id));
    check("grant_pkt", 64'(bus.Packet_IN), 64'(p));
    bus.Packet_Read_en = 1'b1; #1;
    check("pop_onehot", 64'(bus.req_read_en), 64'(oh));
    @(negedge clk);
    bus.Packet_Read_en = 1'b0;
    bus.PSEL = 1'b1; #1;
    check("busy_pvalid", 64'(bus.P_Valid), 64'd0);
    check("busy_flag", 64'(bus.busy), 64'd1);
    check("busy_pkt", 64'(bus.Packet_IN), 64'(p));
    check("busy_nopop", 64'(bus.req_read_en), 64'd0);
    check("rd_fifo_full", 64'(bus.Read_fifo_full), 64'(full_exp));
    if (rd) begin
      bus.Data_Write_en = 1'b1;
      bus.Data_Out = rdata; #1;
      check("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
      check("rsp_data", 64'(bus.rsp_data), 64'(rdata));
    end
    @(negedge clk);
    bus.Data_Write_en = 1'b0;
    bus.Data_Out = '0;
    bus.PENABLE = 1'b1;
    bus.PREADY = (waits == 0);
    repeat (waits) begin
      #1;
      check("wait_pkt", 64'(bus.Packet_IN), 64'(p));
      check("wait_busy", 64'(bus.busy), 64'd1);
      check("wait_nopop", 64'(bus.req_read_en), 64'd0);
      check("wait_id", 64'(bus.grant_id), 64'(id));
      @(negedge clk);
    end
    bus.PREADY = 1'b1; #1;
    check("access_pkt", 64'(bus.Packet_IN), 64'(p));
    @(negedge clk);
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PREADY = 1'b0; #1;
    check("arb_busy", 64'(bus.busy), 64'd0);
    check("arb_pvalid", 64'(bus.P_Valid), 64'd0);
    check("arb_pkt", 64'(bus.Packet_IN), 64'd0);
    check("arb_rsp", 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) pkt[i] = wr_pkt(i);
    bus.req_valid = 4'hF;
    bus.rsp_full = 4'h0;
    bus.Packet_Read_en = 1'b0;
    bus.Data_Write_en = 1'b0;
    bus.Data_Out = '0;
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PREADY = 1'b0;

    // Reset with every requester valid: everything stays quiet
    repeat (2) @(negedge clk);
    #1;
    check("rst_pvalid", 64'(bus.P_Valid), 64'd0);
    check("rst_pkt", 64'(bus.Packet_IN), 64'd0);
    check("rst_pop", 64'(bus.req_read_en), 64'd0);
    check("rst_rsp", 64'(bus.rsp_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_gid", 64'(bus.grant_id), 64'd0);
    rst_n = 1'b1;

`ifdef APB_ARB_FIXED_PRIO_EN
    xfer(0, 1'b0, 32'h0, 1'b0, 0);
    bus.req_valid = 4'b1010;
    xfer(1, 1'b0, 32'h0, 1'b0, 0);
    xfer(1, 1'b0, 32'h0, 1'b0, 0);
    xfer(1, 1'b0, 32'h0, 1'b0, 0);
`else
    // Round-robin order 0,1,2,3,0
    xfer(0, 1'b0, 32'h0, 1'b0, 0);
    xfer(1, 1'b0, 32'h0, 1'b0, 0);
    xfer(2, 1'b0, 32'h0, 1'b0, 0);
    xfer(3, 1'b0, 32'h0, 1'b0, 0);
    xfer(0, 1'b0, 32'h0, 1'b0, 0);

    // Read routing to requester 2
    bus.req_valid = 4'b0100;
    pkt[2] = {1'b0, 32'h0, 8'h10};
    xfer(2, 1'b1, 32'hDEADBEEF, 1'b0, 0);

    // A read with a full response FIFO is skipped. A write with a full
    // response FIFO still goes, and it reports the full flag while busy.
    pkt[2] = wr_pkt(2);
    pkt[1] = {1'b0, 32'h0, 8'h11};
    bus.rsp_full = 4'b1010;
    bus.req_valid = 4'b1010;
    xfer(3, 1'b0, 32'h0, 1'b1, 0);
    bus.req_valid = 4'b0010;
    repeat (2) begin
      @(negedge clk); #1;
      check("full_noskip_busy", 64'(bus.busy), 64'd0);
      check("full_noskip_pv", 64'(bus.P_Valid), 64'd0);
    end
    bus.rsp_full = 4'b0000;
    xfer(1, 1'b0, 32'h0, 1'b0, 0);

    // Wait states in ACCESS
    pkt[1] = wr_pkt(1);
    bus.req_valid = 4'hF;
    xfer(2, 1'b0, 32'h0, 1'b0, 5);
    xfer(3, 1'b0, 32'h0, 1'b0, 0);

    // FIFO flush while granted: no pop, and the pointer does not move
    bus.req_valid = 4'b0001;
    @(negedge clk); #1;
    check("flush_grant", 64'(bus.grant_id), 64'd0);
    check("flush_pv", 64'(bus.P_Valid), 64'd1);
    bus.req_valid = 4'b0000; #1;
    check("flush_nopop", 64'(bus.req_read_en), 64'd0);
    @(negedge clk); #1;
    check("flush_arb", 64'(bus.busy), 64'd0);
    bus.req_valid = 4'hF;
    xfer(0, 1'b0, 32'h0, 1'b0, 0);

    // Asynchronous reset in the middle of BUSY
    @(negedge clk); #1;
    check("mid_grant", 64'(bus.grant_id), 64'd1);
    bus.Packet_Read_en = 1'b1;
    @(negedge clk);
    bus.Packet_Read_en = 1'b0; #1;
    check("mid_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0; #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_pkt", 64'(bus.Packet_IN), 64'd0);
    check("mid_rst_gid", 64'(bus.grant_id), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
